// File: rtl/x_23k640_pkg.sv
// ---------------------------------------------------------------------------
// x_23K640_pkg
// Shared types and constants for the two-requester 23K640 SRAM front-end
// arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT_A, GRANT_B)
//   REQ_A/REQ_B : requester identifiers held in last_q / rd_owner_q
//   next_addr   : sequential-address helper (16-bit wrap) for burst hops
// ---------------------------------------------------------------------------
package x_23K640_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Address that continues a burst from addr; wraps 0xFFFF -> 0x0000.
  function automatic logic [15:0] next_addr(input logic [15:0] addr);
    return addr + 16'd1;
  endfunction

endpackage

// File: rtl/x_23k640_sck_gen.sv
// ---------------------------------------------------------------------------
// x_23K640_sck_gen
// SPI clock divider. An 8-bit counter runs 0..CLK_DIV-1; the last count
// raises o_advance for one cycle and toggles o_sck, so o_sck has a period of
// 2*CLK_DIV i_clk cycles. With CLK_DIV=1 o_advance is high every cycle.
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst     : asynchronous active-high reset
//   o_advance : one-cycle pulse at each SCK half-period boundary
//   o_sck     : divided serial clock, 0 out of reset
// Parameter CLK_DIV : i_clk cycles per SCK half-period, 1..255.
// ---------------------------------------------------------------------------
module x_23K640_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_advance,
  output logic o_sck
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       wrap;

  always_comb begin
    wrap  = (cnt_q == LAST_CNT);
    cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    sck_d = sck_q ^ wrap;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 8'd0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  // With CLK_DIV=1 the reset count already equals the wrap value, so the
  // pulse is masked explicitly to keep the output low during reset.
  assign o_advance = wrap & ~i_rst;
  assign o_sck     = sck_q;

endmodule

// File: rtl/x_23k640_arb.sv
// ---------------------------------------------------------------------------
// x_23k640_arb
// Two-requester (a, b) round-robin arbiter in front of a 23K640 SPI SRAM
// engine, plus the engine's SCK divider.
// Ports:
//   i_clk, i_rst                     : clock / asynchronous active-high reset
//   i_p_valid/_rd_n_wr/_addr/_wdata  : request from requester p (a, b), held
//                                      stable until o_p_accept
//   o_p_accept                       : engine accepted p's request
//   o_p_ready, o_p_rdata             : read data return for p
//   o_advance, o_sck                 : divider outputs for the engine
//   o_valid/_rd_n_wr/_addr/_wdata    : granted request towards the engine
//   i_accept                         : engine takes the presented request
//   i_ready, i_rdata                 : engine read data return
// Optional build macro X_23K640_ARB_STICKY_EN: an idle decision re-grants
// the last-served requester when its new request continues the previous
// access (same direction, address + 1), so engine burst hops are not broken
// up by the other requester.
// ---------------------------------------------------------------------------
module x_23k640_arb
  import x_23K640_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester a
  input  logic        i_a_valid,
  output logic        o_a_accept,
  input  logic        i_a_rd_n_wr,
  input  logic [15:0] i_a_addr,
  input  logic [7:0]  i_a_wdata,
  output logic        o_a_ready,
  output logic [7:0]  o_a_rdata,
  // requester b
  input  logic        i_b_valid,
  output logic        o_b_accept,
  input  logic        i_b_rd_n_wr,
  input  logic [15:0] i_b_addr,
  input  logic [7:0]  i_b_wdata,
  output logic        o_b_ready,
  output logic [7:0]  o_b_rdata,
  // engine side
  output logic        o_advance,
  output logic        o_sck,
  output logic        o_valid,
  input  logic        i_accept,
  output logic        o_rd_n_wr,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  input  logic        i_ready,
  input  logic [7:0]  i_rdata
);

  arb_state_t  grant_q, grant_d;
  logic        last_q, last_d;
  logic        rd_owner_q, rd_owner_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        last_rd_q, last_rd_d;
  logic        a_hop, b_hop;

  x_23K640_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_advance (o_advance),
    .o_sck     (o_sck)
  );

  // Burst-continuation detection for the last-served requester.
`ifdef X_23K640_ARB_STICKY_EN
  assign a_hop = (last_q == REQ_A) && i_a_valid && (i_a_rd_n_wr == last_rd_q)
                 && (i_a_addr == next_addr(last_addr_q));
  assign b_hop = (last_q == REQ_B) && i_b_valid && (i_b_rd_n_wr == last_rd_q)
                 && (i_b_addr == next_addr(last_addr_q));
`else
  assign a_hop = 1'b0;
  assign b_hop = 1'b0;
`endif

  always_comb begin
    grant_d     = grant_q;
    last_d      = last_q;
    rd_owner_d  = rd_owner_q;
    last_addr_d = last_addr_q;
    last_rd_d   = last_rd_q;
    o_valid     = 1'b0;
    o_rd_n_wr   = 1'b0;
    o_addr      = 16'd0;
    o_wdata     = 8'd0;
    o_a_accept  = 1'b0;
    o_b_accept  = 1'b0;

    case (grant_q)
      IDLE: begin
        if (a_hop) begin
          grant_d = GRANT_A;
        end else if (b_hop) begin
          grant_d = GRANT_B;
        end else if (i_a_valid && i_b_valid) begin
          // Tie: the requester not served last wins.
          grant_d = (last_q == REQ_A) ? GRANT_B : GRANT_A;
        end else if (i_a_valid) begin
          grant_d = GRANT_A;
        end else if (i_b_valid) begin
          grant_d = GRANT_B;
        end
      end

      GRANT_A: begin
        o_valid    = i_a_valid;
        o_rd_n_wr  = i_a_rd_n_wr;
        o_addr     = i_a_addr;
        o_wdata    = i_a_wdata;
        o_a_accept = i_accept;
        if (i_accept) begin
          grant_d     = IDLE;
          last_d      = REQ_A;
          last_addr_d = i_a_addr;
          last_rd_d   = i_a_rd_n_wr;
          if (i_a_rd_n_wr) rd_owner_d = REQ_A;
        end else if (!i_a_valid) begin
          // Requester withdrew without an accept: drop the grant.
          grant_d = IDLE;
        end
      end

      GRANT_B: begin
        o_valid    = i_b_valid;
        o_rd_n_wr  = i_b_rd_n_wr;
        o_addr     = i_b_addr;
        o_wdata    = i_b_wdata;
        o_b_accept = i_accept;
        if (i_accept) begin
          grant_d     = IDLE;
          last_d      = REQ_B;
          last_addr_d = i_b_addr;
          last_rd_d   = i_b_rd_n_wr;
          if (i_b_rd_n_wr) rd_owner_d = REQ_B;
        end else if (!i_b_valid) begin
          grant_d = IDLE;
        end
      end

      default: grant_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q     <= IDLE;
      last_q      <= REQ_B;
      rd_owner_q  <= REQ_A;
      last_addr_q <= 16'd0;
      last_rd_q   <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      rd_owner_q  <= rd_owner_d;
      last_addr_q <= last_addr_d;
      last_rd_q   <= last_rd_d;
    end
  end

  // Read return is steered by the owner of the last accepted read; data is
  // broadcast. Both are forced low while reset is held.
  assign o_a_ready = ~i_rst & i_ready & (rd_owner_q == REQ_A);
  assign o_b_ready = ~i_rst & i_ready & (rd_owner_q == REQ_B);
  assign o_a_rdata = i_rst ? 8'd0 : i_rdata;
  assign o_b_rdata = i_rst ? 8'd0 : i_rdata;

endmodule
